lvds_tx_framer: RTL and testbench



---
 rtl/lvds_link_pkg.sv | 21 ++
 rtl/lvds_frame_cksum.sv | 40 ++++
 rtl/lvds_tx_framer.sv | 160 ++++++++++++++++
 tb/tb_lvds_tx_framer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_link_pkg.sv
// Shared LVDS link-layer definitions: K-code bytes, framer FSM states and defaults.
// Used by both the transmit framer and the receive deframer.
package lvds_link_pkg;

  localparam logic [7:0] K_COMMA = 8'hBC;  // K28.5
  localparam logic [7:0] K_SOF   = 8'hFB;  // K27.7
  localparam logic [7:0] K_EOF   = 8'hFD;  // K29.7
  localparam logic [7:0] K_FILL  = 8'h1C;  // K28.0

  localparam int unsigned TRAIN_LEN_DEF = 64;

  typedef enum logic [2:0] {
    ST_TRAIN,
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_CSUM,
    ST_EOF
  } link_state_e;

endpackage

// File: rtl/lvds_frame_cksum.sv
// Per-frame mod-256 payload checksum and byte counter; clear has priority over enable.
module lvds_frame_cksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum,
  output logic [7:0] len
);

  logic [7:0] sum_q, sum_d;
  logic [7:0] len_q, len_d;

  always_comb begin
    sum_d = sum_q;
    len_d = len_q;
    if (clr) begin
      sum_d = '0;
      len_d = '0;
    end else if (en) begin
      sum_d = sum_q + din;
      len_d = len_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      len_q <= '0;
    end else begin
      sum_q <= sum_d;
      len_q <= len_d;
    end
  end

  assign sum = sum_q;
  assign len = len_q;

endmodule

// File: rtl/lvds_tx_framer.sv
// LVDS transmit framer: comma training bursts, then SOF/payload/checksum/EOF frames
// with idle commas between them. Every output is registered from the next state.
module lvds_tx_framer
  import lvds_link_pkg::*;
#(
  parameter int unsigned TRAIN_LEN = TRAIN_LEN_DEF,
  parameter int unsigned MAX_LEN   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       train_req,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_k,
  output logic       train_busy,
  output logic       frame_trunc
);

  localparam logic [15:0] CNT_LAST = 16'(TRAIN_LEN - 1);
  localparam logic [7:0]  LEN_LAST = 8'(MAX_LEN - 1);

  link_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        cut_q, cut_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_k_q, tx_k_d;
  logic        s_ready_q, s_ready_d;
  logic        train_busy_q, train_busy_d;
  logic        frame_trunc_q, frame_trunc_d;

  logic        ck_clr, ck_en, take;
  logic [7:0]  sum, len;

  lvds_frame_cksum u_cksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ck_clr),
    .en    (ck_en),
    .din   (s_data),
    .sum   (sum),
    .len   (len)
  );

  assign take = s_valid && s_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | train_req;
    cut_d   = cut_q;
    ck_clr  = 1'b0;
    ck_en   = 1'b0;
    s_ready_d = 1'b0;

    case (state_q)
      ST_TRAIN: begin
        pend_d = 1'b0;
        if (train_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_IDLE: begin
        if (pend_q || train_req) state_d = ST_TRAIN;
        else if (s_valid)        state_d = ST_SOF;
      end
      // DATA stays one extra cycle with s_ready low to show the final byte.
      ST_SOF, ST_DATA: begin
        if (!s_ready_q) begin
          state_d = ST_CSUM;
        end else begin
          state_d   = ST_DATA;
          s_ready_d = 1'b1;
          if (take) begin
            ck_en = 1'b1;
            if (s_last || len == LEN_LAST) begin
              s_ready_d = 1'b0;
              cut_d     = !s_last;
            end
          end
        end
      end
      ST_CSUM: state_d = ST_EOF;
      ST_EOF:  state_d = (pend_q || train_req) ? ST_TRAIN : ST_IDLE;
      default: state_d = ST_TRAIN;
    endcase

    if (state_d == ST_TRAIN && state_q != ST_TRAIN) begin
      pend_d = 1'b0;
      cnt_d  = '0;
    end
    if (state_d == ST_SOF) begin
      ck_clr    = 1'b1;
      s_ready_d = 1'b1;
      cut_d     = 1'b0;
    end

    tx_data_d     = K_COMMA;
    tx_k_d        = 1'b1;
    frame_trunc_d = 1'b0;
    case (state_d)
      ST_SOF:  tx_data_d = K_SOF;
      ST_DATA: begin
        if (take) begin
          tx_data_d = s_data;
          tx_k_d    = 1'b0;
        end else begin
          tx_data_d = K_FILL;
        end
      end
      ST_CSUM: begin
        tx_data_d     = sum;
        tx_k_d        = 1'b0;
        frame_trunc_d = cut_q;
      end
      ST_EOF:  tx_data_d = K_EOF;
      default: tx_data_d = K_COMMA;
    endcase
    train_busy_d = (state_d == ST_TRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_TRAIN;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      cut_q         <= 1'b0;
      tx_data_q     <= K_COMMA;
      tx_k_q        <= 1'b1;
      s_ready_q     <= 1'b0;
      train_busy_q  <= 1'b1;
      frame_trunc_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      cut_q         <= cut_d;
      tx_data_q     <= tx_data_d;
      tx_k_q        <= tx_k_d;
      s_ready_q     <= s_ready_d;
      train_busy_q  <= train_busy_d;
      frame_trunc_q <= frame_trunc_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_k        = tx_k_q;
  assign train_busy  = train_busy_q;
  assign frame_trunc = frame_trunc_q;

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Bench for lvds_tx_framer: packets are split into expected frames from the framing
// rules and compared against the captured non-comma, non-fill output stream.
module tb_lvds_tx_framer;

  localparam int unsigned TRAIN_LEN = 64;
  localparam int unsigned MAX_LEN   = 4;

  logic       clk = 1'b0;
  logic       rst_n, train_req, s_valid, s_last;
  logic [7:0] s_data;
  logic       s_ready, tx_k, train_busy, frame_trunc;
  logic [7:0] tx_data;

  lvds_tx_framer #(.TRAIN_LEN(TRAIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .train_req   (train_req),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .tx_data     (tx_data),
    .tx_k        (tx_k),
    .train_busy  (train_busy),
    .frame_trunc (frame_trunc)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // capture word: {trunc, busy, ready, k, data}
  logic        cap_en = 1'b0;
  logic [11:0] cap[$];
  logic [9:0]  exp_q[$];
  int unsigned exp_trunc;
  logic [7:0]  pkt[$];
  int unsigned gap[$];

  always @(negedge clk) if (cap_en) cap.push_back({frame_trunc, train_busy, s_ready, tx_k, tx_data});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_scoreboard();
    cap.delete();
    exp_q.delete();
    exp_trunc = 0;
  endtask

  // Expected frames for the packet in pkt: chunks of at most MAX_LEN bytes.
  task automatic model_packet();
    int unsigned i = 0;
    while (i < pkt.size()) begin
      int unsigned n;
      logic [7:0]  sum;
      logic        tr;
      n   = pkt.size() - i;
      if (n > MAX_LEN) n = MAX_LEN;
      sum = 8'h00;
      exp_q.push_back({1'b0, 1'b1, 8'hFB});
      for (int unsigned k = 0; k < n; k++) begin
        exp_q.push_back({1'b0, 1'b0, pkt[i+k]});
        sum = sum + pkt[i+k];
      end
      tr = (n == MAX_LEN) && (i + n < pkt.size());
      if (tr) exp_trunc++;
      exp_q.push_back({tr, 1'b0, sum});
      exp_q.push_back({1'b0, 1'b1, 8'hFD});
      i += n;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic drive_byte(input logic [7:0] d, input logic last, input int unsigned g, input logic req);
    logic r;
    logic ok = 1'b0;
    s_valid = 1'b0;
    repeat (g) begin
      s_data = 8'($urandom);
      s_last = 1'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = d; s_last = last; train_req = req;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); r = s_ready;
      @(posedge clk); #1;
      train_req = 1'b0;
      if (r) begin ok = 1'b1; break; end
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send_packet(input int req_at);
    for (int unsigned i = 0; i < pkt.size(); i++)
      drive_byte(pkt[i], i == pkt.size() - 1, gap[i], req_at == int'(i));
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic verify_stream(input string tag);
    int unsigned k = 0, trc = 0, bad = 0;
    for (int unsigned i = 0; i < cap.size(); i++) begin
      logic [11:0] e;
      e = cap[i];
      if (e[11]) trc++;
      if (e[8:0] == {1'b1, 8'hFD} && i + 1 < cap.size() && cap[i+1][8:0] != {1'b1, 8'hBC}) bad++;
      if (!(e[8] && (e[7:0] == 8'hBC || e[7:0] == 8'h1C))) begin
        if (k < exp_q.size()) check({tag, "_word"}, {e[11], e[8:0]}, exp_q[k]);
        k++;
      end
    end
    check({tag, "_nwords"}, k, exp_q.size());
    check({tag, "_trunc_pulses"}, trc, exp_trunc);
    check({tag, "_comma_after_eof"}, bad, 0);
  endtask

  // Burst of exactly TRAIN_LEN busy commas from index start, then idle commas only.
  task automatic check_burst(input string tag, input int unsigned start);
    int unsigned run = 0, nonc = 0, rdy = 0, late = 0;
    int unsigned i = start;
    while (i < cap.size() && cap[i][10]) begin run++; i++; end
    for (int unsigned j = start; j < cap.size(); j++) begin
      if (cap[j][8:0] != {1'b1, 8'hBC}) nonc++;
      if (cap[j][9]) rdy++;
      if (j >= start + run && cap[j][10]) late++;
    end
    check({tag, "_busy_run"}, run, TRAIN_LEN);
    check({tag, "_non_comma"}, nonc, 0);
    check({tag, "_ready_high"}, rdy, 0);
    check({tag, "_busy_after"}, late, 0);
    check({tag, "_idle_seen"}, cap.size() > start + run, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned fills;
    int unsigned fd_idx;
    rst_n = 1'b0; train_req = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data", tx_data, 8'hBC);
    check("rst_tx_k", tx_k, 1);
    check("rst_s_ready", s_ready, 0);
    check("rst_train_busy", train_busy, 1);
    check("rst_frame_trunc", frame_trunc, 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_scoreboard();
    cap_en = 1'b1;
    wait_cycles(80);
    cap_en = 1'b0;
    check_burst("boot", 0);

    // Directed frames: plain, with a 2-cycle gap, and a MAX_LEN cut.
    clear_scoreboard();
    cap_en = 1'b1;
    pkt = '{8'h11, 8'h22, 8'h33}; gap = '{0, 0, 0};
    model_packet(); send_packet(-1);
    pkt = '{8'h11, 8'h22, 8'h33}; gap = '{0, 0, 2};
    model_packet(); send_packet(-1);
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; gap = '{0, 0, 0, 0, 0, 0};
    model_packet(); send_packet(-1);
    wait_cycles(10);
    cap_en = 1'b0;
    verify_stream("directed");
    fills = 0;
    foreach (cap[i]) if (cap[i][8:0] == {1'b1, 8'h1C}) fills++;
    check("directed_fill_count", fills, 2);

    // Random packets, lengths across the MAX_LEN boundary, random gaps.
    clear_scoreboard();
    cap_en = 1'b1;
    for (int p = 0; p < 16; p++) begin
      int unsigned n;
      n = $urandom_range(1, 9);
      pkt.delete(); gap.delete();
      for (int unsigned b = 0; b < n; b++) begin
        pkt.push_back(8'($urandom));
        gap.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      model_packet(); send_packet(-1);
    end
    wait_cycles(10);
    cap_en = 1'b0;
    verify_stream("random");
    fills = 0;
    foreach (cap[i]) if (cap[i][10]) fills++;
    check("random_no_busy", fills, 0);

    // Training request mid-frame: frame finishes, then a full burst.
    clear_scoreboard();
    cap_en = 1'b1;
    pkt = '{8'h11, 8'h22, 8'h33}; gap = '{0, 0, 0};
    model_packet(); send_packet(1);
    wait_cycles(90);
    cap_en = 1'b0;
    verify_stream("treq");
    fd_idx = cap.size();
    foreach (cap[i]) if (fd_idx == cap.size() && cap[i][8:0] == {1'b1, 8'hFD}) fd_idx = i;
    check("treq_eof_found", fd_idx < cap.size(), 1);
    if (fd_idx < cap.size()) check_burst("treq", fd_idx + 1);

    // Reset in the middle of a frame.
    drive_byte(8'hA1, 1'b0, 0, 1'b0);
    drive_byte(8'hA2, 1'b0, 0, 1'b0);
    wait_cycles(1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_scoreboard();
    cap_en = 1'b1;
    @(negedge clk);
    check("midrst_tx_data", tx_data, 8'hBC);
    check("midrst_tx_k", tx_k, 1);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_train_busy", train_busy, 1);
    wait_cycles(80);
    cap_en = 1'b0;
    check_burst("midrst", 0);

    // Recovery frame after the abandoned one.
    clear_scoreboard();
    cap_en = 1'b1;
    pkt = '{8'h05, 8'h07}; gap = '{0, 0};
    model_packet(); send_packet(-1);
    wait_cycles(10);
    cap_en = 1'b0;
    verify_stream("recover");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
